octal_key_selector: RTL

- Upstream stage that drives the 16-bit one-hot input of the two-digit octal 7-segment display decoder.
- Takes three raw, bouncing, active-low board pushbuttons and synchronises and debounces them.
- Maintains a 4-bit selection value (0..15) with up/down/clear control and hold-to-auto-repeat.
- Emits the value as a registered one-hot word. An all-zero word is used as the blank code, which the decoder maps to dark digits.

---
 rtl/octal_key_selector.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/octal_key_selector.sv
`default_nettype none
// =============================================================================
// octal_key_selector: debounced up/down/clear pushbutton selector that drives
// a registered 16-bit one-hot word (all-zero = blank). Revision 1.0
// =============================================================================
module octal_key_selector #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_RATE     = 5000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btn_up_n,
  input  logic        btn_down_n,
  input  logic        btn_clr_n,
  input  logic        blank,
  output logic [15:0] onehot,
  output logic [3:0]  value,
  output logic        step
);

  localparam int C_NBTN    = 3;
  localparam int C_NREP    = 2;
  localparam int C_BTN_CLR = 2;
  localparam int C_DB_W    = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int C_TMR_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int C_TMR_W   = (C_TMR_MAX > 2) ? $clog2(C_TMR_MAX) : 1;

  localparam logic [C_DB_W-1:0]  C_DB_LAST    = C_DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [C_TMR_W-1:0] C_DELAY_LAST = C_TMR_W'(REPEAT_DELAY - 1);
  localparam logic [C_TMR_W-1:0] C_RATE_LAST  = C_TMR_W'(REPEAT_RATE - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } rep_state_e;

  // Bit order: 0 = up, 1 = down, 2 = clear.
  logic [C_NBTN-1:0] btn_raw;
  logic [C_NBTN-1:0] pressed;
  logic [C_NREP-1:0] rep_ev;

  assign btn_raw = {btn_clr_n, btn_down_n, btn_up_n};

  // Two-flop synchroniser followed by a run-length debouncer per button.
  for (genvar i = 0; i < C_NBTN; i++) begin : g_btn
    logic [1:0]        sync_q;
    logic [C_DB_W-1:0] cnt_q, cnt_d;
    logic              stable_q, stable_d;

    always_comb begin
      cnt_d    = '0;
      stable_d = stable_q;
      if (sync_q[1] != stable_q) begin
        if (cnt_q == C_DB_LAST) begin
          stable_d = sync_q[1];
        end else begin
          cnt_d = cnt_q + C_DB_W'(1);
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync_q   <= 2'b11;
        cnt_q    <= '0;
        stable_q <= 1'b1;
      end else begin
        sync_q   <= {sync_q[0], btn_raw[i]};
        cnt_q    <= cnt_d;
        stable_q <= stable_d;
      end
    end

    assign pressed[i] = ~stable_q;
  end

  // Press / hold-to-repeat event generators for up and down.
  for (genvar j = 0; j < C_NREP; j++) begin : g_rep
    rep_state_e         state_q, state_d;
    logic [C_TMR_W-1:0] tmr_q, tmr_d;
    logic               ev;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q <= ST_IDLE;
        tmr_q   <= '0;
      end else begin
        state_q <= state_d;
        tmr_q   <= tmr_d;
      end
    end

    always_comb begin
      state_d = state_q;
      tmr_d   = tmr_q + C_TMR_W'(1);
      ev      = 1'b0;
      case (state_q)
        ST_IDLE: begin
          tmr_d = '0;
          if (pressed[j]) begin
            state_d = ST_DELAY;
            ev      = 1'b1;
          end
        end
        ST_DELAY: begin
          if (!pressed[j]) begin
            state_d = ST_IDLE;
            tmr_d   = '0;
          end else if (tmr_q == C_DELAY_LAST) begin
            state_d = ST_REPEAT;
            tmr_d   = '0;
            ev      = 1'b1;
          end
        end
        ST_REPEAT: begin
          if (!pressed[j]) begin
            state_d = ST_IDLE;
            tmr_d   = '0;
          end else if (tmr_q == C_RATE_LAST) begin
            tmr_d = '0;
            ev    = 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          tmr_d   = '0;
        end
      endcase
    end

    assign rep_ev[j] = ev;
  end

  // Clear fires once on the debounced press edge.
  logic clr_seen_q;
  logic clr_ev;

  assign clr_ev = pressed[C_BTN_CLR] & ~clr_seen_q;

  logic [3:0]  value_q, value_d;
  logic [15:0] onehot_q, onehot_d;
  logic        step_q, step_d;

  always_comb begin
    value_d = value_q;
    step_d  = 1'b0;
    if (clr_ev) begin
      value_d = 4'd0;
      step_d  = 1'b1;
    end else if (rep_ev[0] && !rep_ev[1]) begin
      value_d = value_q + 4'd1;
      step_d  = 1'b1;
    end else if (rep_ev[1] && !rep_ev[0]) begin
      value_d = value_q - 4'd1;
      step_d  = 1'b1;
    end
    // Built from the next value so onehot and value always agree.
    onehot_d = blank ? 16'h0000 : (16'h0001 << value_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clr_seen_q <= 1'b0;
      value_q    <= 4'd0;
      onehot_q   <= 16'h0001;
      step_q     <= 1'b0;
    end else begin
      clr_seen_q <= pressed[C_BTN_CLR];
      value_q    <= value_d;
      onehot_q   <= onehot_d;
      step_q     <= step_d;
    end
  end

  assign value  = value_q;
  assign onehot = onehot_q;
  assign step   = step_q;

endmodule
`default_nettype wire
